// File: rtl/rx_iq_capture_if.sv
// Stream bundle for rx_iq_capture: I/Q sample input, arm, framed output.
// master = sample source / sink side, slave = capture block side.
interface rx_iq_capture_if #(
  parameter int DATA_W = 16
);
  logic                     din_valid;
  logic signed [DATA_W-1:0] din_i;
  logic signed [DATA_W-1:0] din_q;
  logic                     arm;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_last;
  logic                     busy;
  logic                     detected;
  logic                     overflow;

  modport master (
    output din_valid, din_i, din_q, arm, out_ready,
    input  out_valid, out_i, out_q, out_last,
    input  busy, detected, overflow
  );

  modport slave (
    input  din_valid, din_i, din_q, arm, out_ready,
    output out_valid, out_i, out_q, out_last,
    output busy, detected, overflow
  );
endinterface

// File: rtl/rx_iq_capture.sv
// Echo detector + fixed-length frame capture into a show-ahead FIFO.
// Ports: clk, reset (async active-low), io (rx_iq_capture_if.slave).
// Optional RX_DC_BLOCK_EN: per-channel DC removal, adds one stage.
module rx_iq_capture #(
  parameter int DATA_W      = 16,
  parameter int THRESH      = 2048,
  parameter int HOLD_CNT    = 4,
  parameter int CAPTURE_LEN = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input logic clk,
  input logic reset,
  rx_iq_capture_if.slave io
);

  typedef enum logic [1:0] {
    IDLE, SEARCH, CAPTURE, DRAIN
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLD_CNT + 1);
  localparam int CW = $clog2(CAPTURE_LEN + 1);
  localparam logic [DATA_W:0] TH = (DATA_W+1)'(THRESH);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD_CNT - 1);
  localparam logic [CW-1:0] CL_M1 = CW'(CAPTURE_LEN - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic                     s_valid;
  logic signed [DATA_W-1:0] s_i;
  logic signed [DATA_W-1:0] s_q;

`ifdef RX_DC_BLOCK_EN
  // dc carries 6 fractional bits; two spare integer bits keep x-dc exact.
  localparam int FW = DATA_W + 8;
  localparam logic signed [FW-1:0] SMAX =
    {{9{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [FW-1:0] SMIN =
    {{9{1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [FW-1:0]     dci_q, dcq_q;
  logic                     sv_q;
  logic signed [DATA_W-1:0] si_q, sq_q;

  function automatic logic signed [FW-1:0] dc_step(
    input logic signed [DATA_W-1:0] x,
    input logic signed [FW-1:0]     dc
  );
    logic signed [FW-1:0] xe;
    xe = {{2{x[DATA_W-1]}}, x, 6'b0};
    return dc + ((xe - dc) >>> 6);
  endfunction

  function automatic logic signed [DATA_W-1:0] dc_fix(
    input logic signed [DATA_W-1:0] x,
    input logic signed [FW-1:0]     dc
  );
    logic signed [FW-1:0] d;
    d = {{8{x[DATA_W-1]}}, x} - (dc >>> 6);
    if (d > SMAX) return SMAX[DATA_W-1:0];
    else if (d < SMIN) return SMIN[DATA_W-1:0];
    else return d[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dci_q <= '0;
      dcq_q <= '0;
      sv_q  <= 1'b0;
      si_q  <= '0;
      sq_q  <= '0;
    end else begin
      sv_q <= io.din_valid;
      if (io.din_valid) begin
        si_q  <= dc_fix(io.din_i, dci_q);
        sq_q  <= dc_fix(io.din_q, dcq_q);
        dci_q <= dc_step(io.din_i, dci_q);
        dcq_q <= dc_step(io.din_q, dcq_q);
      end
    end
  end

  assign s_valid = sv_q;
  assign s_i     = si_q;
  assign s_q     = sq_q;
`else
  assign s_valid = io.din_valid;
  assign s_i     = io.din_i;
  assign s_q     = io.din_q;
`endif

  // |x| is formed one bit wider so |-2^(W-1)| is exact.
  logic [DATA_W:0] abs_i, abs_q, mag;
  logic            hot;

  always_comb begin
    abs_i = s_i[DATA_W-1] ? -{1'b1, s_i} : {1'b0, s_i};
    abs_q = s_q[DATA_W-1] ? -{1'b1, s_q} : {1'b0, s_q};
    mag   = abs_i + abs_q;
    hot   = (mag >= TH);
  end

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [CW-1:0]   ccnt_q, ccnt_d;
  logic            det_q, det_d;
  logic            ovf_q;
  logic            push_req, push, pop;

  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, rp_q;
  logic [AW:0]         cnt_q;

  assign pop  = (cnt_q != '0) && io.out_ready;
  // A full FIFO still takes a push when the head leaves this cycle.
  assign push = push_req && ((cnt_q != DEPTH) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      ccnt_q  <= '0;
      det_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ccnt_q  <= ccnt_d;
      det_q   <= det_d;
      if (state_q == IDLE && io.arm) ovf_q <= 1'b0;
      else if (push_req && !push) ovf_q <= 1'b1;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      if (push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {s_i, s_q};
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    ccnt_d   = ccnt_q;
    det_d    = 1'b0;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.arm) begin
          state_d = SEARCH;
          hcnt_d  = '0;
        end
      end
      SEARCH: begin
        if (s_valid) begin
          if (!hot) begin
            hcnt_d = '0;
          end else if (hcnt_q == HOLD_M1) begin
            push_req = 1'b1;
            det_d    = 1'b1;
            ccnt_d   = CW'(1);
            state_d  = (CAPTURE_LEN == 1) ? DRAIN : CAPTURE;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end
      CAPTURE: begin
        if (s_valid) begin
          push_req = 1'b1;
          ccnt_d   = ccnt_q + CW'(1);
          if (ccnt_q == CL_M1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io.busy      = (state_q != IDLE);
    io.detected  = det_q;
    io.overflow  = ovf_q;
    io.out_valid = (cnt_q != '0);
    io.out_last  = io.out_valid && (state_q == DRAIN)
                   && (cnt_q == (AW+1)'(1));
    io.out_i     = '0;
    io.out_q     = '0;
    if (io.out_valid) begin
      io.out_i = mem_q[rp_q][2*DATA_W-1 -: DATA_W];
      io.out_q = mem_q[rp_q][DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_rx_iq_capture.sv
// Testbench for rx_iq_capture: directed frames with a scoreboard monitor.
// Second instance covers the full-scale threshold and a 1-sample frame.
module tb_rx_iq_capture;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rx_iq_capture_if #(.DATA_W(16)) bus ();
  rx_iq_capture_if #(.DATA_W(16)) bus2 ();

  rx_iq_capture #(
    .DATA_W(16), .THRESH(2048), .HOLD_CNT(4),
    .CAPTURE_LEN(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  rx_iq_capture #(
    .DATA_W(16), .THRESH(32768), .HOLD_CNT(1),
    .CAPTURE_LEN(1), .FIFO_DEPTH(2)
  ) dut2 (
    .clk(clk), .reset(reset), .io(bus2)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    bus.din_valid = 1'b1;
    bus.din_i = 16'(i);
    bus.din_q = 16'(q);
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic send2(input int i, input int q);
    bus2.din_valid = 1'b1;
    bus2.din_i = 16'(i);
    bus2.din_q = 16'(q);
    tick();
    bus2.din_valid = 1'b0;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic expect_out(input int i, input int q, input bit last);
    exp_t e;
    e.i = 16'(i);
    e.q = 16'(q);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check("drain_done_busy", int'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.din_valid = 1'b0;
    bus.din_i = '0;
    bus.din_q = '0;
    bus.arm = 1'b0;
    bus.out_ready = 1'b0;
    bus2.din_valid = 1'b0;
    bus2.din_i = '0;
    bus2.din_q = '0;
    bus2.arm = 1'b0;
    bus2.out_ready = 1'b0;

    // Scoreboard monitor: every accepted head is checked in order.
    fork
      forever begin
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_pop", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_i", int'(bus.out_i), int'(e.i));
            check("sb_q", int'(bus.out_q), int'(e.q));
            check("sb_last", int'(bus.out_last), int'(e.last));
          end
        end
      end
    join_none

    repeat (3) tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out_i", int'(bus.out_i), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_detected", int'(bus.detected), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    reset = 1'b1;
    tick();

    // Frame with boundary magnitudes: 2048 hot, 2047 cold.
    bus.out_ready = 1'b1;
    do_arm();
    check("t1_busy_armed", int'(bus.busy), 1);
    send(2048, 0);
    send(-1024, 1024);
    send(3000, 0);
    check("t1_no_det_3hot", int'(bus.detected), 0);
    send(1024, -1023);
    for (int k = 1; k <= 12; k++) begin
      if (k >= 4 && k <= 11) expect_out(3000 + k, -k, k == 11);
      send(3000 + k, -k);
      if (k == 3) check("t1_no_det_k3", int'(bus.detected), 0);
      if (k == 4) check("t1_det_k4", int'(bus.detected), 1);
      if (k == 5) check("t1_det_pulse", int'(bus.detected), 0);
    end
    wait_idle();
    check("t1_ovf", int'(bus.overflow), 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Downstream stalled: only the first four frame samples survive.
    bus.out_ready = 1'b0;
    do_arm();
    for (int k = 0; k <= 10; k++) begin
      if (k >= 3 && k <= 6) expect_out(2500 + 100 * k, -k, k == 6);
      send(2500 + 100 * k, -k);
    end
    check("t3_ovf_set", int'(bus.overflow), 1);
    check("t3_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    wait_idle();
    check("t3_ovf_sticky", int'(bus.overflow), 1);
    check("t3_sb_empty", exp_q.size(), 0);

    // Push into a full FIFO while the head pops.
    bus.out_ready = 1'b0;
    do_arm();
    check("t4_arm_clears_ovf", int'(bus.overflow), 0);
    for (int k = 0; k <= 10; k++) begin
      if (k >= 3) expect_out(-2500 - 100 * k, k, k == 10);
      send(-2500 - 100 * k, k);
      if (k == 6) bus.out_ready = 1'b1;
    end
    wait_idle();
    check("t4_no_ovf", int'(bus.overflow), 0);
    check("t4_sb_empty", exp_q.size(), 0);

    // Reset mid-capture clears outputs without a clock edge.
    bus.out_ready = 1'b0;
    do_arm();
    for (int k = 0; k < 6; k++) send(4000, 0);
    check("t5_busy_pre", int'(bus.busy), 1);
    #3;
    reset = 1'b0;
    #1;
    check("t5_valid", int'(bus.out_valid), 0);
    check("t5_busy", int'(bus.busy), 0);
    check("t5_out_i", int'(bus.out_i), 0);
    check("t5_out_q", int'(bus.out_q), 0);
    check("t5_last", int'(bus.out_last), 0);
    check("t5_det", int'(bus.detected), 0);
    check("t5_ovf", int'(bus.overflow), 0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send(4000, 0);
    check("t5_idle_busy", int'(bus.busy), 0);
    check("t5_idle_valid", int'(bus.out_valid), 0);
    do_arm();
    for (int k = 0; k < 11; k++) begin
      if (k >= 3) expect_out(5000 + k, 7, k == 10);
      send(5000 + k, 7);
    end
    wait_idle();
    check("t5_sb_empty", exp_q.size(), 0);

    // Full-scale threshold, one-sample frame.
    bus2.arm = 1'b1;
    tick();
    bus2.arm = 1'b0;
    send2(-32767, 0);
    check("t2_not_hot", int'(bus2.detected), 0);
    check("t2_busy", int'(bus2.busy), 1);
    send2(-32768, 0);
    check("t2_hot_det", int'(bus2.detected), 1);
    check("t2_valid", int'(bus2.out_valid), 1);
    check("t2_out_i", int'(bus2.out_i), -32768);
    check("t2_last", int'(bus2.out_last), 1);
    bus2.out_ready = 1'b1;
    tick();
    check("t2_popped", int'(bus2.out_valid), 0);
    tick();
    check("t2_idle", int'(bus2.busy), 0);

    repeat (2) tick();
    check("sb_final_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
